// File: rtl/mprj_wb_arbiter_if.sv
// Bus bundle for the user-project Wishbone arbiter: both upstream masters plus the downstream slave port.
// The arbiter uses the slave modport; the environment (cores, user project) uses the master modport.
interface mprj_wb_arbiter_if;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;

    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;

    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        output m1_ack_o, m1_err_o, m1_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_ack_i, s_dat_i
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        input  m1_ack_o, m1_err_o, m1_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_ack_i, s_dat_i
    );
endinterface

// File: rtl/mprj_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with a transfer watchdog for the user-project bus.
// One transfer per grant; a DONE bubble keeps stb low between back-to-back transfers.
module mprj_wb_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              core_clk,
    input  logic              core_rst,
    mprj_wb_arbiter_if.slave  bus,
    output logic              s_iena_o,
    output logic              timeout_flag_o,
    input  logic              timeout_clr_i
);
    localparam int unsigned    CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_gnt, w_gnt_nxt;
    logic          r_last, w_last_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_flag, w_flag_nxt;

    logic w_req0, w_req1, w_gcyc;
    logic w_xfer, w_ack, w_to;

    assign w_req0         = bus.m0_cyc_i & bus.m0_stb_i;
    assign w_req1         = bus.m1_cyc_i & bus.m1_stb_i;
    assign w_gcyc         = r_gnt ? bus.m1_cyc_i : bus.m0_cyc_i;
    assign timeout_flag_o = r_flag;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flag  <= w_flag_nxt;
        end
    end

    // Abort outranks ack, which outranks timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_xfer      = 1'b0;
        w_ack       = 1'b0;
        w_to        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req0 || w_req1) begin
                    w_state_nxt = XFER;
                    w_cnt_nxt   = '0;
                    w_gnt_nxt   = (w_req0 && w_req1) ? ~r_last : w_req1;
                end
            end
            XFER: begin
                w_xfer = 1'b1;
                if (!w_gcyc) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_gnt;
                end else if (bus.s_ack_i) begin
                    w_ack       = 1'b1;
                    w_state_nxt = DONE;
                    w_last_nxt  = r_gnt;
                end else if (r_cnt == CNT_LAST) begin
                    w_to        = 1'b1;
                    w_state_nxt = DONE;
                    w_last_nxt  = r_gnt;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_flag_nxt = w_to ? 1'b1 : (timeout_clr_i ? 1'b0 : r_flag);
    end

    always_comb begin
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_sel_o  = '0;
        bus.s_adr_o  = '0;
        bus.s_dat_o  = '0;
        s_iena_o     = w_xfer;
        bus.m0_ack_o = 1'b0;
        bus.m0_err_o = 1'b0;
        bus.m0_dat_o = '0;
        bus.m1_ack_o = 1'b0;
        bus.m1_err_o = 1'b0;
        bus.m1_dat_o = '0;
        if (w_xfer) begin
            if (r_gnt) begin
                bus.s_cyc_o  = bus.m1_cyc_i;
                bus.s_stb_o  = bus.m1_stb_i;
                bus.s_we_o   = bus.m1_we_i;
                bus.s_sel_o  = bus.m1_sel_i;
                bus.s_adr_o  = bus.m1_adr_i;
                bus.s_dat_o  = bus.m1_dat_i;
                bus.m1_ack_o = w_ack | w_to;
                bus.m1_err_o = w_to;
                bus.m1_dat_o = w_to ? '1 : (w_ack ? bus.s_dat_i : '0);
            end else begin
                bus.s_cyc_o  = bus.m0_cyc_i;
                bus.s_stb_o  = bus.m0_stb_i;
                bus.s_we_o   = bus.m0_we_i;
                bus.s_sel_o  = bus.m0_sel_i;
                bus.s_adr_o  = bus.m0_adr_i;
                bus.s_dat_o  = bus.m0_dat_i;
                bus.m0_ack_o = w_ack | w_to;
                bus.m0_err_o = w_to;
                bus.m0_dat_o = w_to ? '1 : (w_ack ? bus.s_dat_i : '0);
            end
        end
    end
endmodule

// File: tb/tb_mprj_wb_arbiter.sv
// Directed, table-driven bench for mprj_wb_arbiter (TIMEOUT = 4): one vector per clock cycle,
// plus a hand-written asynchronous-reset sequence.
module tb_mprj_wb_arbiter;
    logic core_clk = 1'b0;
    logic core_rst = 1'b1;
    logic timeout_clr_i = 1'b0;
    logic s_iena_o, timeout_flag_o;

    mprj_wb_arbiter_if bus ();

    mprj_wb_arbiter #(.TIMEOUT(4)) dut (
        .core_clk       (core_clk),
        .core_rst       (core_rst),
        .bus            (bus),
        .s_iena_o       (s_iena_o),
        .timeout_flag_o (timeout_flag_o),
        .timeout_clr_i  (timeout_clr_i)
    );

    always #5 core_clk = ~core_clk;

    localparam logic [31:0] Z      = 32'h0;
    localparam logic [31:0] F      = 32'hFFFF_FFFF;
    localparam logic [31:0] M0_DAT = 32'h1111_1111;
    localparam logic [31:0] M1_DAT = 32'h2222_2222;
    localparam logic [31:0] AM     = 32'h3000_0010;
    localparam logic [31:0] BM     = 32'h3000_0020;

    // g: 0 = no transfer, 1 = m0 granted in XFER, 2 = m1 granted in XFER
    typedef struct {
        logic        r0;  logic [31:0] a0;
        logic        r1;  logic [31:0] a1;
        logic        ack; logic [31:0] sdat;
        logic        clr;
        int unsigned g;   logic        stb;
        logic [1:0]  ae0; logic [31:0] d0;
        logic [1:0]  ae1; logic [31:0] d1;
        logic        flag;
    } vec_t;

    vec_t tv[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                                input logic ack, input logic [31:0] sdat, input logic clr,
                                input int unsigned g, input logic stb,
                                input logic [1:0] ae0, input logic [31:0] d0,
                                input logic [1:0] ae1, input logic [31:0] d1, input logic flag);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1; v.ack = ack; v.sdat = sdat; v.clr = clr;
        v.g = g; v.stb = stb; v.ae0 = ae0; v.d0 = d0; v.ae1 = ae1; v.d1 = d1; v.flag = flag;
        return v;
    endfunction

    function automatic logic [140:0] pack_act();
        return {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, s_iena_o, bus.s_sel_o, bus.s_adr_o, bus.s_dat_o,
                bus.m0_ack_o, bus.m0_err_o, bus.m0_dat_o, bus.m1_ack_o, bus.m1_err_o, bus.m1_dat_o,
                timeout_flag_o};
    endfunction

    function automatic logic [140:0] pack_exp(input vec_t v);
        logic cyc, we, iena;
        logic [3:0] sel;
        logic [31:0] adr, dat;
        cyc = 1'b0; we = 1'b0; iena = 1'b0; sel = '0; adr = '0; dat = '0;
        if (v.g == 1) begin
            cyc = v.stb; iena = 1'b1; sel = 4'hF; adr = v.a0; dat = M0_DAT;
        end else if (v.g == 2) begin
            cyc = v.stb; we = 1'b1; iena = 1'b1; sel = 4'h3; adr = v.a1; dat = M1_DAT;
        end
        return {cyc, cyc, we, iena, sel, adr, dat, v.ae0, v.d0, v.ae1, v.d1, v.flag};
    endfunction

    task automatic check(input string name, input logic [140:0] act, input logic [140:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                         input logic ack, input logic [31:0] sdat, input logic clr);
        bus.m0_cyc_i = r0; bus.m0_stb_i = r0; bus.m0_adr_i = a0;
        bus.m1_cyc_i = r1; bus.m1_stb_i = r1; bus.m1_adr_i = a1;
        bus.s_ack_i = ack; bus.s_dat_i = sdat; timeout_clr_i = clr;
    endtask

    initial begin
        bus.m0_we_i = 1'b0; bus.m0_sel_i = 4'hF; bus.m0_dat_i = M0_DAT;
        bus.m1_we_i = 1'b1; bus.m1_sel_i = 4'h3; bus.m1_dat_i = M1_DAT;
        drive(1'b0, Z, 1'b0, Z, 1'b0, Z, 1'b0);

        // contention after reset, then strict alternation while both keep requesting
        tv.push_back(mk(1, AM, 1, BM, 0, Z, 0,            0, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, AM, 1, BM, 1, 32'hA0A0_A0A0, 0, 1, 1, 2'b10, 32'hA0A0_A0A0, 2'b00, Z, 0));
        tv.push_back(mk(1, AM, 1, BM, 0, Z, 0,            0, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, AM, 1, BM, 0, Z, 0,            0, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, AM, 1, BM, 1, 32'hB1B1_B1B1, 0, 2, 1, 2'b00, Z, 2'b10, 32'hB1B1_B1B1, 0));
        tv.push_back(mk(1, AM, 1, BM, 0, Z, 0,            0, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, AM, 1, BM, 0, Z, 0,            0, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, AM, 1, BM, 1, 32'hC2C2_C2C2, 0, 1, 1, 2'b10, 32'hC2C2_C2C2, 2'b00, Z, 0));
        tv.push_back(mk(0, Z, 0, Z, 0, Z, 0,              0, 0, 2'b00, Z, 2'b00, Z, 0));
        // single read, ack on second XFER cycle
        tv.push_back(mk(1, 32'h3000_0004, 0, Z, 0, Z, 0,  0, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, 32'h3000_0004, 0, Z, 0, Z, 0,  1, 1, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, 32'h3000_0004, 0, Z, 1, 32'hDEAD_BEEF, 0, 1, 1, 2'b10, 32'hDEAD_BEEF, 2'b00, Z, 0));
        tv.push_back(mk(0, Z, 0, Z, 0, Z, 0,              0, 0, 2'b00, Z, 2'b00, Z, 0));
        // m1 timeout: four XFER cycles, err on the last, sticky flag until clear
        tv.push_back(mk(0, Z, 1, 32'h3000_0040, 0, Z, 0,  0, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(0, Z, 1, 32'h3000_0040, 0, Z, 0,  2, 1, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(0, Z, 1, 32'h3000_0040, 0, Z, 0,  2, 1, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(0, Z, 1, 32'h3000_0040, 0, Z, 0,  2, 1, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(0, Z, 1, 32'h3000_0040, 0, Z, 0,  2, 1, 2'b00, Z, 2'b11, F, 0));
        tv.push_back(mk(0, Z, 1, 32'h3000_0040, 0, Z, 0,  0, 0, 2'b00, Z, 2'b00, Z, 1));
        tv.push_back(mk(0, Z, 0, Z, 0, Z, 0,              0, 0, 2'b00, Z, 2'b00, Z, 1));
        tv.push_back(mk(0, Z, 0, Z, 0, Z, 1,              0, 0, 2'b00, Z, 2'b00, Z, 1));
        tv.push_back(mk(0, Z, 0, Z, 0, Z, 0,              0, 0, 2'b00, Z, 2'b00, Z, 0));
        // ack exactly on the last allowed cycle: normal completion, no flag
        tv.push_back(mk(1, 32'h3000_0008, 0, Z, 0, Z, 0,  0, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, 32'h3000_0008, 0, Z, 0, Z, 0,  1, 1, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, 32'h3000_0008, 0, Z, 0, Z, 0,  1, 1, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, 32'h3000_0008, 0, Z, 0, Z, 0,  1, 1, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, 32'h3000_0008, 0, Z, 1, 32'h1234_5678, 0, 1, 1, 2'b10, 32'h1234_5678, 2'b00, Z, 0));
        tv.push_back(mk(0, Z, 0, Z, 0, Z, 0,              0, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(0, Z, 0, Z, 0, Z, 0,              0, 0, 2'b00, Z, 2'b00, Z, 0));
        // timeout coincident with clear: set wins
        tv.push_back(mk(1, 32'h3000_000C, 0, Z, 0, Z, 0,  0, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, 32'h3000_000C, 0, Z, 0, Z, 0,  1, 1, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, 32'h3000_000C, 0, Z, 0, Z, 0,  1, 1, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, 32'h3000_000C, 0, Z, 0, Z, 0,  1, 1, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, 32'h3000_000C, 0, Z, 0, Z, 1,  1, 1, 2'b11, F, 2'b00, Z, 0));
        tv.push_back(mk(0, Z, 0, Z, 0, Z, 0,              0, 0, 2'b00, Z, 2'b00, Z, 1));
        tv.push_back(mk(0, Z, 0, Z, 0, Z, 1,              0, 0, 2'b00, Z, 2'b00, Z, 1));
        tv.push_back(mk(0, Z, 0, Z, 0, Z, 0,              0, 0, 2'b00, Z, 2'b00, Z, 0));
        // m0 aborts after two XFER cycles; pending m1 is served afterwards
        tv.push_back(mk(1, 32'h3000_0014, 0, Z, 0, Z, 0,  0, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, 32'h3000_0014, 1, 32'h3000_0050, 0, Z, 0, 1, 1, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(1, 32'h3000_0014, 1, 32'h3000_0050, 0, Z, 0, 1, 1, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(0, 32'h3000_0014, 1, 32'h3000_0050, 0, Z, 0, 1, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(0, Z, 1, 32'h3000_0050, 0, Z, 0,  0, 0, 2'b00, Z, 2'b00, Z, 0));
        tv.push_back(mk(0, Z, 1, 32'h3000_0050, 1, 32'h55AA_55AA, 0, 2, 1, 2'b00, Z, 2'b10, 32'h55AA_55AA, 0));
        tv.push_back(mk(0, Z, 0, Z, 0, Z, 0,              0, 0, 2'b00, Z, 2'b00, Z, 0));

        #12;
        check("reset_state", pack_act(), '0);
        @(posedge core_clk); #1;
        core_rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].r0, tv[i].a0, tv[i].r1, tv[i].a1, tv[i].ack, tv[i].sdat, tv[i].clr);
            @(negedge core_clk);
            check($sformatf("vec%0d", i), pack_act(), pack_exp(tv[i]));
            @(posedge core_clk); #1;
        end

        // asynchronous reset while m1 is mid-transfer
        drive(1'b0, Z, 1'b1, 32'h3000_0060, 1'b0, Z, 1'b0);
        @(posedge core_clk); #1;
        @(negedge core_clk);
        check("rst_pre_stb", 141'(bus.s_stb_o), 141'(1'b1));
        #1;
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'h0BAD_0BAD;
        core_rst = 1'b1;
        #1;
        check("rst_async_zero", pack_act(), '0);
        @(posedge core_clk); #1;
        core_rst = 1'b0;
        drive(1'b1, 32'h3000_0070, 1'b1, 32'h3000_0060, 1'b0, Z, 1'b0);
        @(posedge core_clk); #1;
        check("rst_tie_adr", 141'(bus.s_adr_o), 141'(32'h3000_0070));
        bus.s_ack_i = 1'b1;
        #1;
        check("rst_tie_ack", 141'({bus.m0_ack_o, bus.m1_ack_o}), 141'(2'b10));
        @(posedge core_clk); #1;
        drive(1'b0, Z, 1'b0, Z, 1'b0, Z, 1'b0);
        @(posedge core_clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mprj_wb_arbiter.md
# mprj_wb_arbiter

Two-master, one-slave Wishbone arbiter with bus watchdog for the user-project Wishbone port. It shares the user project bus between the management core (master 0) and the housekeeping SPI back-door (master 1). Grants are round-robin, one transfer per grant. Any transfer the user project never acknowledges is terminated after a bounded number of cycles, so the CPU cannot hang on an unresponsive or unpowered user design.

## Interface
Parameters:
- TIMEOUT, 255: cycles a granted transfer may wait for `s_ack_i` before forced termination. Legal range 2..65535.

Ports:
- core_clk  in  1  single clock; all state on rising edge.
- core_rst  in  1  reset; **one clock; reset is asynchronous and active-high**.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (mgmt core) Wishbone control.
- m0_sel_i  in  4  master 0 byte selects.
- m0_adr_i, m0_dat_i  in  32 each  master 0 address and write data.
- m0_ack_o, m0_err_o  out  1 each  master 0 ack and error (error only on timeout).
- m0_dat_o  out  32  master 0 read data.
- m1_*  same set as m0_*  master 1 (housekeeping SPI back-door).
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to user project.
- s_sel_o  out  4  to user project.
- s_adr_o, s_dat_o  out  32 each  to user project.
- s_ack_i  in  1  from user project.
- s_dat_i  in  32  from user project.
- s_iena_o  out  1  enables user return signals; high only in XFER.
- timeout_flag_o  out  1  sticky; set by any timeout.
- timeout_clr_i  in  1  synchronous clear of `timeout_flag_o`.

## Operation
- Request: mN_req = mN_cyc_i & mN_stb_i.
- Registered state: FSM {IDLE, XFER, DONE}, `gnt` (0/1), `last` (last master served), `cnt` (width $clog2(TIMEOUT)), `timeout_flag_o`.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: gnt <= that master; go to XFER; cnt <= 0.
  - Both request: gnt <= ~last; go to XFER.
- XFER:
  - s_cyc/stb/we/sel/adr/dat_o are a combinational mux of the granted master's inputs.
  - s_iena_o = 1.
  - The non-granted master sees ack = err = 0 and dat = 0.
- XFER, normal end: s_ack_i = 1.
  - Granted mN_ack_o = 1 in the same cycle; mN_dat_o = s_dat_i.
  - Next state DONE; last <= gnt.
- XFER, timeout: cnt == TIMEOUT-1 and s_ack_i = 0.
  - Granted mN_ack_o = 1 and mN_err_o = 1 for that one cycle; mN_dat_o = 32'hFFFF_FFFF.
  - timeout_flag_o <= 1; next state DONE; last <= gnt.
- XFER, otherwise: cnt increments by 1 (no wrap is reachable).
- XFER, abort: granted master drops cyc_i.
  - Next state IDLE; no ack, no err; last <= gnt; flag unchanged.
  - Abort takes priority over timeout in the same cycle.
- DONE: all s_* outputs 0, s_iena_o = 0, acks 0; go to IDLE unconditionally. This bubble guarantees the slave sees stb low between transfers.
- Outside XFER: s_cyc_o, s_stb_o, s_we_o, s_iena_o = 0; s_sel_o, s_adr_o, s_dat_o = 0; mN_ack/err/dat_o = 0.
- Simultaneous events:
  - s_ack_i on the timeout cycle: normal ack wins; err = 0; flag not set.
  - timeout_clr_i with a timeout in the same cycle: set wins.
- Reset (async, any state including mid-XFER):
  - state IDLE, gnt 0, last 1 (so master 0 wins the first tie), cnt 0, timeout_flag_o 0.
  - All outputs 0 immediately.

## Timing
- Arbitration latency: request sampled in IDLE at edge N; s_stb_o high from cycle N+1.
- Ack path: s_ack_i to mN_ack_o and s_dat_i to mN_dat_o are combinational, zero cycles.
- Worst-case transfer: TIMEOUT cycles in XFER, then err.
- Back-to-back: ack at cycle K, DONE at K+1, IDLE samples at K+2, next s_stb_o at K+3. Minimum repeat period is 3 cycles for a zero-wait slave.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1…
- timeout_flag_o: changes only on a clock edge; rises the edge after the timeout cycle.

## Test plan
- Single read: m0 read adr 0x3000_0004; slave acks on the 2nd XFER cycle with 0xDEADBEEF. Expect m0_ack_o with m0_dat_o = 0xDEADBEEF, m0_err_o = 0, s_stb_o low in DONE.
- Contention: m0 and m1 request at the same edge after reset. Expect m0 granted first, then m1; s_adr_o follows each master's address; m1_ack_o never overlaps m0_ack_o.
- Timeout: TIMEOUT = 4; slave never acks. Expect exactly 4 XFER cycles, then m1_ack_o = m1_err_o = 1 with dat 0xFFFFFFFF; timeout_flag_o = 1 until timeout_clr_i pulses.
- Boundary: ack on cycle cnt = TIMEOUT-1. Expect normal ack, err = 0, flag stays 0. Also timeout_clr_i coincident with a timeout: expect flag = 1.
- Abort: m0 drops cyc after 2 XFER cycles. Expect IDLE next cycle with no m0_ack_o; a pending m1 request is granted after that.
- Reset mid-XFER: assert core_rst with s_stb_o high. Expect all outputs 0 asynchronously; after release, m0 wins the first tie.
